// File: rtl/json_token_serializer_if.sv
// Token input stream and JSON byte output stream of json_token_serializer.
// master: token source / byte sink side; slave: the serializer.
interface json_token_serializer_if;
  logic        tok_valid;
  logic        tok_ready;
  logic [3:0]  tok_type;
  logic [31:0] tok_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;

  modport master (
    output tok_valid, tok_type, tok_data, out_ready,
    input  tok_ready, out_valid, out_data
  );

  modport slave (
    input  tok_valid, tok_type, tok_data, out_ready,
    output tok_ready, out_valid, out_data
  );
endinterface

// File: rtl/json_token_serializer.sv
// Streaming JSON writer: token stream in, compact JSON text out, one byte per cycle.
// Define JSON_ESCAPE_EN to escape string characters; otherwise string bytes pass through raw.
module json_token_serializer #(
  parameter int unsigned MAX_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  json_token_serializer_if.slave         bus,
  output logic                           err,
  output logic [$clog2(MAX_DEPTH+1)-1:0] depth,
  output logic                           idle
);

  localparam int unsigned DW      = $clog2(MAX_DEPTH + 1);
  localparam int unsigned SEQ_MAX = 8;

  localparam logic [3:0] T_OBJ_BEGIN = 4'd0;
  localparam logic [3:0] T_OBJ_END   = 4'd1;
  localparam logic [3:0] T_ARR_BEGIN = 4'd2;
  localparam logic [3:0] T_ARR_END   = 4'd3;
  localparam logic [3:0] T_STR_OPEN  = 4'd4;
  localparam logic [3:0] T_STR_CHAR  = 4'd5;
  localparam logic [3:0] T_STR_CLOSE = 4'd6;
  localparam logic [3:0] T_INT       = 4'd7;
  localparam logic [3:0] T_BOOL      = 4'd8;
  localparam logic [3:0] T_NULL      = 4'd9;

  localparam logic [7:0] C_QUOTE  = 8'h22;
  localparam logic [7:0] C_BSLASH = 8'h5C;
  localparam logic [7:0] C_COMMA  = 8'h2C;
  localparam logic [7:0] C_COLON  = 8'h3A;
  localparam logic [7:0] C_MINUS  = 8'h2D;
  localparam logic [7:0] C_ZERO   = 8'h30;

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_INT_CONV, S_ERR_DROP} state_e;

  state_e             state_q, state_n;
  logic               out_valid_q, out_valid_n;
  logic [7:0]         out_data_q, out_data_n;
  logic               err_q, err_n;
  logic [DW-1:0]      depth_q, depth_n;
  logic               root_done_q, root_done_n;
  logic               in_string_q, in_string_n;
  logic               str_key_q, str_key_n;
  logic [MAX_DEPTH:0] is_obj_q, is_obj_n;
  logic [MAX_DEPTH:0] first_q, first_n;
  logic [MAX_DEPTH:0] ek_q, ek_n;
  logic [7:0]         seq_q [SEQ_MAX];
  logic [7:0]         seq_n [SEQ_MAX];
  logic [3:0]         seq_len_q, seq_len_n;
  logic [3:0]         seq_idx_q, seq_idx_n;
  logic               int_pend_q, int_pend_n;
  logic [31:0]        mag_q, mag_n;
  logic [3:0]         pow_q, pow_n;

  function automatic logic [31:0] pow10(input logic [3:0] p);
    case (p)
      4'd1:    return 32'd10;
      4'd2:    return 32'd100;
      4'd3:    return 32'd1000;
      4'd4:    return 32'd10000;
      4'd5:    return 32'd100000;
      4'd6:    return 32'd1000000;
      4'd7:    return 32'd10000000;
      4'd8:    return 32'd100000000;
      4'd9:    return 32'd1000000000;
      default: return 32'd1;
    endcase
  endfunction

`ifdef JSON_ESCAPE_EN
  function automatic logic [7:0] hex_char(input logic [3:0] v);
    return (v < 4'd10) ? (C_ZERO + {4'h0, v}) : (8'h57 + {4'h0, v});
  endfunction
`endif

  // Handshake and status
  logic slot_free, accept;
  assign slot_free     = !out_valid_q || bus.out_ready;
  assign bus.tok_ready = (state_q == S_IDLE) && slot_free && !rst;
  assign accept        = bus.tok_valid && bus.tok_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign err           = err_q;
  assign depth         = depth_q;
  assign idle          = (state_q == S_IDLE) && !out_valid_q && !in_string_q;

  // Integer magnitude (unsigned, so -2^31 maps to 2^31) and its leading power of ten
  logic [31:0] tok_abs;
  logic [3:0]  start_pow;
  always_comb begin
    tok_abs   = bus.tok_data[31] ? (~bus.tok_data + 32'd1) : bus.tok_data;
    start_pow = 4'd0;
    for (int unsigned p = 1; p < 10; p++) begin
      if (tok_abs >= pow10(4'(p))) start_pow = 4'(p);
    end
  end

  // Digit unit: successive subtraction of one power; IDLE borrows it for a separator-less INT
  logic [31:0] du_mag, du_rem;
  logic [3:0]  du_pow, du_digit;
  always_comb begin
    du_mag   = (state_q == S_INT_CONV) ? mag_q : tok_abs;
    du_pow   = (state_q == S_INT_CONV) ? pow_q : start_pow;
    du_rem   = du_mag;
    du_digit = 4'd0;
    for (int unsigned k = 0; k < 9; k++) begin
      if (du_rem >= pow10(du_pow)) begin
        du_rem   = du_rem - pow10(du_pow);
        du_digit = du_digit + 4'd1;
      end
    end
  end

  // Token decode: legality, context actions and the byte sequence (separator + body)
  logic        d_err, d_push, d_push_obj, d_pop, d_value, d_key;
  logic        d_str_open, d_str_close, d_int, d_comma;
  logic [47:0] d_body;
  logic [2:0]  d_blen;
  logic [7:0]  d_seq [SEQ_MAX];
  logic [3:0]  d_len;
  logic        top_obj, top_first, top_ek, at_root, key_pos;
  logic [7:0]  ch;
  always_comb begin
    d_err = 1'b0; d_push = 1'b0; d_push_obj = 1'b0; d_pop = 1'b0;
    d_value = 1'b0; d_key = 1'b0; d_str_open = 1'b0; d_str_close = 1'b0;
    d_int = 1'b0; d_comma = 1'b0; d_body = 48'h0; d_blen = 3'd0;
    ch        = bus.tok_data[7:0];
    top_obj   = is_obj_q[depth_q];
    top_first = first_q[depth_q];
    top_ek    = ek_q[depth_q];
    at_root   = (depth_q == '0);
    key_pos   = !at_root && top_obj && top_ek;
    if (in_string_q) begin
      case (bus.tok_type)
        T_STR_CHAR: begin
`ifdef JSON_ESCAPE_EN
          if (ch == C_QUOTE || ch == C_BSLASH) begin d_body = {C_BSLASH, ch, 32'h0}; d_blen = 3'd2; end
          else if (ch == 8'h0A) begin d_body = {C_BSLASH, "n", 32'h0}; d_blen = 3'd2; end
          else if (ch == 8'h0D) begin d_body = {C_BSLASH, "r", 32'h0}; d_blen = 3'd2; end
          else if (ch == 8'h09) begin d_body = {C_BSLASH, "t", 32'h0}; d_blen = 3'd2; end
          else if (ch < 8'h20) begin
            d_body = {C_BSLASH, "u00", hex_char(ch[7:4]), hex_char(ch[3:0])};
            d_blen = 3'd6;
          end else begin d_body = {ch, 40'h0}; d_blen = 3'd1; end
`else
          d_body = {ch, 40'h0};
          d_blen = 3'd1;
`endif
        end
        T_STR_CLOSE: begin
          d_str_close = 1'b1;
          d_body      = str_key_q ? {C_QUOTE, C_COLON, 32'h0} : {C_QUOTE, 40'h0};
          d_blen      = str_key_q ? 3'd2 : 3'd1;
        end
        default: d_err = 1'b1;
      endcase
    end else begin
      case (bus.tok_type)
        T_OBJ_END: begin
          if (key_pos) begin d_pop = 1'b1; d_body = {8'h7D, 40'h0}; d_blen = 3'd1; end
          else d_err = 1'b1;
        end
        T_ARR_END: begin
          if (!at_root && !top_obj) begin d_pop = 1'b1; d_body = {8'h5D, 40'h0}; d_blen = 3'd1; end
          else d_err = 1'b1;
        end
        T_OBJ_BEGIN, T_ARR_BEGIN, T_STR_OPEN, T_INT, T_BOOL, T_NULL: begin
          if (key_pos) begin
            if (bus.tok_type == T_STR_OPEN) begin
              d_key = 1'b1; d_str_open = 1'b1; d_comma = !top_first;
              d_body = {C_QUOTE, 40'h0}; d_blen = 3'd1;
            end else d_err = 1'b1;
          end else if (at_root && root_done_q) begin
            d_err = 1'b1;
          end else if ((bus.tok_type == T_OBJ_BEGIN || bus.tok_type == T_ARR_BEGIN) &&
                       depth_q == DW'(MAX_DEPTH)) begin
            d_err = 1'b1;
          end else begin
            d_value = 1'b1;
            d_comma = !at_root && !top_obj && !top_first;
            case (bus.tok_type)
              T_OBJ_BEGIN: begin d_push = 1'b1; d_push_obj = 1'b1; d_body = {8'h7B, 40'h0}; d_blen = 3'd1; end
              T_ARR_BEGIN: begin d_push = 1'b1; d_body = {8'h5B, 40'h0}; d_blen = 3'd1; end
              T_STR_OPEN:  begin d_str_open = 1'b1; d_body = {C_QUOTE, 40'h0}; d_blen = 3'd1; end
              T_INT: begin
                d_int  = 1'b1;
                d_body = {C_MINUS, 40'h0};
                d_blen = bus.tok_data[31] ? 3'd1 : 3'd0;
              end
              T_BOOL: begin
                d_body = bus.tok_data[0] ? {"true", 16'h0} : {"false", 8'h0};
                d_blen = bus.tok_data[0] ? 3'd4 : 3'd5;
              end
              default: begin d_body = {"null", 16'h0}; d_blen = 3'd4; end
            endcase
          end
        end
        default: d_err = 1'b1;
      endcase
    end
    for (int unsigned i = 0; i < SEQ_MAX; i++) d_seq[i] = 8'h00;
    if (d_comma) d_seq[0] = C_COMMA;
    for (int unsigned i = 0; i < 6; i++) begin
      if (3'(i) < d_blen) d_seq[3'(i) + {2'b00, d_comma}] = d_body[47 - 8*i -: 8];
    end
    d_len = {1'b0, d_blen} + {3'b000, d_comma};
  end

  // Next-state and output logic
  always_comb begin
    state_n     = state_q;
    out_valid_n = out_valid_q;
    out_data_n  = out_data_q;
    err_n       = err_q;
    depth_n     = depth_q;
    root_done_n = root_done_q;
    in_string_n = in_string_q;
    str_key_n   = str_key_q;
    is_obj_n    = is_obj_q;
    first_n     = first_q;
    ek_n        = ek_q;
    seq_n       = seq_q;
    seq_len_n   = seq_len_q;
    seq_idx_n   = seq_idx_q;
    int_pend_n  = int_pend_q;
    mag_n       = mag_q;
    pow_n       = pow_q;
    if (out_valid_q && bus.out_ready) out_valid_n = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && d_err) begin
          err_n   = 1'b1;
          state_n = S_ERR_DROP;
        end else if (accept) begin
          if (d_value) begin
            if (at_root) root_done_n = 1'b1;
            else begin
              first_n[depth_q] = 1'b0;
              if (top_obj) ek_n[depth_q] = 1'b1;
            end
          end
          if (d_key) first_n[depth_q] = 1'b0;
          if (d_str_open) begin in_string_n = 1'b1; str_key_n = d_key; end
          if (d_str_close) begin
            in_string_n = 1'b0;
            if (str_key_q) ek_n[depth_q] = 1'b0;
          end
          if (d_push) begin
            is_obj_n[depth_q + DW'(1)] = d_push_obj;
            first_n[depth_q + DW'(1)]  = 1'b1;
            ek_n[depth_q + DW'(1)]     = 1'b1;
            depth_n                    = depth_q + DW'(1);
          end
          if (d_pop) depth_n = depth_q - DW'(1);
          seq_n       = d_seq;
          seq_len_n   = d_len;
          seq_idx_n   = 4'd1;
          int_pend_n  = d_int;
          mag_n       = tok_abs;
          pow_n       = start_pow;
          out_valid_n = 1'b1;
          if (d_len != 4'd0) begin
            out_data_n = d_seq[0];
            if (d_len > 4'd1) state_n = S_EMIT;
            else if (d_int)   state_n = S_INT_CONV;
          end else begin
            // Non-negative INT with no separator: leading digit goes out right away
            out_data_n = C_ZERO + {4'h0, du_digit};
            mag_n      = du_rem;
            if (start_pow != 4'd0) begin
              pow_n   = start_pow - 4'd1;
              state_n = S_INT_CONV;
            end
          end
        end
      end
      S_EMIT: begin
        if (slot_free) begin
          out_valid_n = 1'b1;
          out_data_n  = seq_q[seq_idx_q[2:0]];
          seq_idx_n   = seq_idx_q + 4'd1;
          if (seq_idx_q + 4'd1 == seq_len_q) state_n = int_pend_q ? S_INT_CONV : S_IDLE;
        end
      end
      S_INT_CONV: begin
        if (slot_free) begin
          out_valid_n = 1'b1;
          out_data_n  = C_ZERO + {4'h0, du_digit};
          mag_n       = du_rem;
          if (pow_q == 4'd0) state_n = S_IDLE;
          else               pow_n   = pow_q - 4'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      err_q       <= 1'b0;
      depth_q     <= '0;
      root_done_q <= 1'b0;
      in_string_q <= 1'b0;
      str_key_q   <= 1'b0;
      is_obj_q    <= '0;
      first_q     <= '0;
      ek_q        <= '0;
      for (int unsigned i = 0; i < SEQ_MAX; i++) seq_q[i] <= 8'h00;
      seq_len_q   <= 4'd0;
      seq_idx_q   <= 4'd0;
      int_pend_q  <= 1'b0;
      mag_q       <= 32'd0;
      pow_q       <= 4'd0;
    end else begin
      state_q     <= state_n;
      out_valid_q <= out_valid_n;
      out_data_q  <= out_data_n;
      err_q       <= err_n;
      depth_q     <= depth_n;
      root_done_q <= root_done_n;
      in_string_q <= in_string_n;
      str_key_q   <= str_key_n;
      is_obj_q    <= is_obj_n;
      first_q     <= first_n;
      ek_q        <= ek_n;
      for (int unsigned i = 0; i < SEQ_MAX; i++) seq_q[i] <= seq_n[i];
      seq_len_q   <= seq_len_n;
      seq_idx_q   <= seq_idx_n;
      int_pend_q  <= int_pend_n;
      mag_q       <= mag_n;
      pow_q       <= pow_n;
    end
  end

endmodule

// File: tb/tb_json_token_serializer.sv
// Directed self-checking bench for json_token_serializer; expected text is hand-written per scenario.
module tb_json_token_serializer;

  localparam logic [3:0] OBJ_B = 4'd0, OBJ_E = 4'd1, ARR_B = 4'd2, ARR_E = 4'd3;
  localparam logic [3:0] S_OPEN = 4'd4, S_CHAR = 4'd5, S_CLOSE = 4'd6;
  localparam logic [3:0] T_INT = 4'd7, T_BOOL = 4'd8, T_NULL = 4'd9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       err;
  logic [4:0] depth;
  logic       idle;
  int         checks = 0;
  int         errors = 0;
  int         hold_viol = 0;
  int         ready_mode = 0;
  int         cyc = 0;
  logic [7:0] rx [$];
  logic       stalled = 1'b0;
  logic [7:0] held = 8'h00;

  json_token_serializer_if bus ();

  json_token_serializer #(.MAX_DEPTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .err   (err),
    .depth (depth),
    .idle  (idle)
  );

  always #5 clk = ~clk;

  initial begin
    bus.tok_valid = 1'b0;
    bus.tok_type  = 4'd0;
    bus.tok_data  = 32'd0;
    bus.out_ready = 1'b1;
  end

  // Sink: 0 always ready, 1 toggle, 2 stalled, 3 ready one cycle in three
  always @(negedge clk) begin
    cyc <= cyc + 1;
    case (ready_mode)
      1:       bus.out_ready = ~bus.out_ready;
      2:       bus.out_ready = 1'b0;
      3:       bus.out_ready = (cyc % 3 == 0);
      default: bus.out_ready = 1'b1;
    endcase
  end

  // Byte capture plus hold-while-stalled monitor, sampled just before each rising edge
  always begin
    @(negedge clk);
    #4;
    if (rst) stalled = 1'b0;
    else begin
      if (stalled && (!bus.out_valid || bus.out_data !== held)) hold_viol++;
      if (bus.out_valid && bus.out_ready) rx.push_back(bus.out_data);
      stalled = bus.out_valid && !bus.out_ready;
      held    = bus.out_data;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic string rx_str();
    string s = "";
    foreach (rx[i]) s = $sformatf("%s%c", s, rx[i]);
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rx.delete();
  endtask

  task automatic send_tok(input logic [3:0] t, input logic [31:0] d);
    bit ok = 1'b0;
    bus.tok_valid = 1'b1;
    bus.tok_type  = t;
    bus.tok_data  = d;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (bus.tok_ready) begin ok = 1'b1; @(posedge clk); break; end
      @(negedge clk);
    end
    if (!ok) begin
      errors++;
      $display("FAIL send_tok timeout: type %0d never accepted", t);
    end
    @(negedge clk);
    bus.tok_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #2;
      if (!bus.out_valid && bus.tok_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      errors++;
      $display("FAIL drain timeout: output never went quiet");
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2;
    checks++;
    if (bus.tok_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 ||
        err !== 1'b0 || depth !== 5'd0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: tok_ready=%b out_valid=%b out_data=%h err=%b depth=%0d idle=%b, want 0 0 00 0 0 1",
               bus.tok_ready, bus.out_valid, bus.out_data, err, depth, idle);
    end
    do_reset();
    #2;
    checks++;
    if (bus.tok_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: tok_ready=%b want 1", bus.tok_ready);
    end
  endtask

  task automatic test_object();
    do_reset();
    send_tok(OBJ_B, 0);   send_tok(S_OPEN, 0); send_tok(S_CHAR, 32'h61); send_tok(S_CLOSE, 0);
    send_tok(T_INT, 5);   send_tok(S_OPEN, 0); send_tok(S_CHAR, 32'h62); send_tok(S_CLOSE, 0);
    send_tok(ARR_B, 0);
    drain();
    checks++;
    if (depth !== 5'd2) begin errors++; $display("FAIL obj_depth_mid: depth=%0d want 2", depth); end
    send_tok(T_BOOL, 1); send_tok(T_NULL, 0); send_tok(ARR_E, 0); send_tok(OBJ_E, 0);
    drain();
    checks++;
    if (rx_str() != "{\"a\":5,\"b\":[true,null]}") begin
      errors++;
      $display("FAIL obj_text: got %s want {\"a\":5,\"b\":[true,null]}", rx_str());
    end
    checks++;
    if (depth !== 5'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL obj_end_state: depth=%0d err=%b want 0 0", depth, err);
    end
  endtask

  task automatic test_int();
    do_reset();
    hold_viol = 0;
    ready_mode = 3;
    send_tok(T_INT, 32'h8000_0000);
    drain();
    checks++;
    if (rx_str() != "-2147483648") begin errors++; $display("FAIL int_min: got %s want -2147483648", rx_str()); end
    do_reset();
    send_tok(T_INT, 32'd0);
    drain();
    checks++;
    if (rx_str() != "0") begin errors++; $display("FAIL int_zero: got %s want 0", rx_str()); end
    checks++;
    if (hold_viol != 0) begin errors++; $display("FAIL int_hold: %0d hold violations want 0", hold_viol); end
    ready_mode = 0;
    do_reset();
    send_tok(ARR_B, 0); send_tok(T_INT, 1); send_tok(T_INT, 32'hFFFF_FFF9);
    send_tok(T_INT, 32'd1000000000); send_tok(ARR_E, 0);
    drain();
    checks++;
    if (rx_str() != "[1,-7,1000000000]") begin
      errors++;
      $display("FAIL int_array: got %s want [1,-7,1000000000]", rx_str());
    end
  endtask

  task automatic test_backpressure();
    int early = 0;
    do_reset();
    hold_viol = 0;
    ready_mode = 1;
    send_tok(T_BOOL, 0);
    for (int i = 0; i < 40; i++) begin
      #3;
      if (bus.tok_ready && (rx.size() + ((bus.out_valid && bus.out_ready) ? 1 : 0)) < 5) early++;
      @(negedge clk);
    end
    ready_mode = 0;
    drain();
    checks++;
    if (rx.size() != 5 || rx_str() != "false") begin
      errors++;
      $display("FAIL bp_text: got %s (%0d bytes) want false (5 bytes)", rx_str(), rx.size());
    end
    checks++;
    if (early != 0) begin errors++; $display("FAIL bp_tok_ready: high early %0d times want 0", early); end
    checks++;
    if (hold_viol != 0) begin errors++; $display("FAIL bp_hold: %0d hold violations want 0", hold_viol); end
  endtask

  task automatic test_mismatch();
    do_reset();
    send_tok(ARR_B, 0);
    drain();
    send_tok(OBJ_E, 0);
    drain();
    checks++;
    if (err !== 1'b1 || rx.size() != 1) begin
      errors++;
      $display("FAIL mismatch_err: err=%b bytes=%0d want 1 1", err, rx.size());
    end
    send_tok(ARR_E, 0);
    drain();
    checks++;
    if (rx_str() != "[]" || depth !== 5'd0 || err !== 1'b1) begin
      errors++;
      $display("FAIL mismatch_recover: got %s depth=%0d err=%b want [] 0 1", rx_str(), depth, err);
    end
  endtask

  task automatic test_depth();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 16; i++) send_tok(ARR_B, 0);
    drain();
    checks++;
    if (err !== 1'b0 || depth !== 5'd16) begin
      errors++;
      $display("FAIL depth_full: err=%b depth=%0d want 0 16", err, depth);
    end
    send_tok(ARR_B, 0);
    drain();
    foreach (rx[i]) if (rx[i] !== 8'h5B) bad++;
    checks++;
    if (err !== 1'b1 || depth !== 5'd16 || rx.size() != 16 || bad != 0) begin
      errors++;
      $display("FAIL depth_overflow: err=%b depth=%0d bytes=%0d non_bracket=%0d want 1 16 16 0",
               err, depth, rx.size(), bad);
    end
  endtask

  task automatic test_escape();
    logic [7:0] exp_q [$];
    int bad = 0;
`ifdef JSON_ESCAPE_EN
    exp_q = '{8'h22, 8'h5C, 8'h22, 8'h5C, 8'h75, 8'h30, 8'h30, 8'h30, 8'h31,
              8'h5C, 8'h5C, 8'h5C, 8'h6E, 8'h22};
`else
    exp_q = '{8'h22, 8'h22, 8'h01, 8'h5C, 8'h0A, 8'h22};
`endif
    do_reset();
    send_tok(S_OPEN, 0); send_tok(S_CHAR, 32'h22); send_tok(S_CHAR, 32'h01);
    send_tok(S_CHAR, 32'h5C); send_tok(S_CHAR, 32'h0A); send_tok(S_CLOSE, 0);
    drain();
    checks++;
    if (rx.size() != exp_q.size()) begin
      errors++;
      $display("FAIL esc_len: got %0d bytes want %0d", rx.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) if (rx[i] !== exp_q[i]) bad++;
      if (bad != 0) begin
        errors++;
        $display("FAIL esc_bytes: %0d differing bytes, first got %h want %h", bad, rx[0], exp_q[0]);
      end
    end
  endtask

  task automatic test_reset_mid_string();
    do_reset();
    send_tok(S_OPEN, 0);
    send_tok(S_CHAR, 32'h78);
    drain();
    ready_mode = 2;
    @(negedge clk);
    send_tok(S_CHAR, 32'h79);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || idle !== 1'b0) begin
      errors++;
      $display("FAIL mid_pending: out_valid=%b idle=%b want 1 0", bus.out_valid, idle);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%b idle=%b want 0 1", bus.out_valid, idle);
    end
    @(negedge clk);
    rst = 1'b0;
    ready_mode = 0;
    rx.delete();
    send_tok(T_INT, 3);
    drain();
    checks++;
    if (rx_str() != "3" || err !== 1'b0) begin
      errors++;
      $display("FAIL mid_after: got %s err=%b want 3 0", rx_str(), err);
    end
  endtask

  initial begin
    test_reset();
    test_object();
    test_int();
    test_backpressure();
    test_mismatch();
    test_depth();
    test_escape();
    test_reset_mid_string();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
